base_hps_led_driver: RTL and testbench

- Consumes the 8-bit LED pattern from the HPS LED PIO output port and drives the board LEDs.
- Adds per-frame PWM brightness, optional blinking and output polarity control.
- Configured through its own Avalon-MM slave on the HPS lightweight bridge.
- Sits between the LED PIO and the top-level LED pins.

---
 rtl/base_hps_led_driver_if.sv | 10 +
 rtl/base_hps_led_driver.sv | 99 +++++++++
 tb/tb_base_hps_led_driver.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/base_hps_led_driver_if.sv
// base_hps_led_driver_if: Avalon-MM slave bus of the LED driver
interface base_hps_led_driver_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/base_hps_led_driver.sv
// base_hps_led_driver: LED PIO pattern to board LEDs with PWM, blink and polarity; LED_DRV_GAMMA_EN squares duty
module base_hps_led_driver #(
  parameter int PRESCALE_W   = 16,
  parameter int PRESCALE_RST = 49,
  parameter int BLINK_RST    = 127
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [7:0]                  pattern_in,
  base_hps_led_driver_if.slave        bus,
  output logic [7:0]                  led_out
);
  logic                  enable_q, enable_d;
  logic                  blink_en_q, blink_en_d;
  logic                  invert_q, invert_d;
  logic [7:0]            duty_q, duty_d;
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;
  logic [7:0]            blink_half_q, blink_half_d;
  logic [PRESCALE_W-1:0] pre_cnt_q, pre_cnt_d;
  logic [7:0]            pwm_cnt_q, pwm_cnt_d;
  logic [7:0]            pattern_q, pattern_d;
  logic [7:0]            blink_cnt_q, blink_cnt_d;
  logic                  blink_phase_q, blink_phase_d;
  logic [7:0]            led_q, led_d;
  logic                  wr, wr_ctrl, wr_duty, wr_pre, wr_blink;
  logic                  tick, frame_start, pwm_on, blink_clr, blink_wrap, blink_hold;
  logic [7:0]            eff_duty;
`ifdef LED_DRV_GAMMA_EN
  logic [15:0]           duty_sq;
`endif
  logic                  unused_wd;
  assign unused_wd = &{1'b0, bus.writedata, 1'b0};
  assign led_out = led_q;
  // Register decode, prescaler/PWM/blink counters, output composition and readback mux
  always_comb begin
    wr          = bus.chipselect && !bus.write_n;
    wr_ctrl     = wr && bus.address == 2'd0;
    wr_duty     = wr && bus.address == 2'd1;
    wr_pre      = wr && bus.address == 2'd2;
    wr_blink    = wr && bus.address == 2'd3;
    tick        = pre_cnt_q == prescale_q;
    frame_start = tick && pwm_cnt_q == 8'hFF;
`ifdef LED_DRV_GAMMA_EN
    duty_sq     = {8'd0, duty_q} * {8'd0, duty_q};
    eff_duty    = duty_q == 8'hFF ? 8'hFF : duty_sq[15:8];
`else
    eff_duty    = duty_q;
`endif
    pwm_on        = eff_duty == 8'hFF || pwm_cnt_q < eff_duty;
    blink_clr     = wr_blink || (wr_ctrl && bus.writedata[1] != blink_en_q);
    blink_hold    = !blink_en_q || blink_clr;
    blink_wrap    = blink_cnt_q == blink_half_q;
    enable_d      = wr_ctrl ? bus.writedata[0] : enable_q;
    blink_en_d    = wr_ctrl ? bus.writedata[1] : blink_en_q;
    invert_d      = wr_ctrl ? bus.writedata[2] : invert_q;
    duty_d        = wr_duty ? bus.writedata[7:0] : duty_q;
    prescale_d    = wr_pre ? bus.writedata[PRESCALE_W-1:0] : prescale_q;
    blink_half_d  = wr_blink ? bus.writedata[7:0] : blink_half_q;
    pre_cnt_d     = (wr_pre || tick) ? '0 : pre_cnt_q + 1'b1;
    pwm_cnt_d     = pwm_cnt_q + {7'd0, tick};
    pattern_d     = frame_start ? pattern_in : pattern_q;
    blink_cnt_d   = blink_hold ? 8'd0 : !frame_start ? blink_cnt_q : blink_wrap ? 8'd0 : blink_cnt_q + 8'd1;
    blink_phase_d = blink_hold ? 1'b1 : (frame_start && blink_wrap) ? ~blink_phase_q : blink_phase_q;
    led_d         = (enable_q ? pattern_q & {8{pwm_on & blink_phase_q}} : 8'h00) ^ {8{invert_q}};
    bus.readdata  = bus.address == 2'd0 ? {23'd0, blink_phase_q, 5'd0, invert_q, blink_en_q, enable_q} :
                    bus.address == 2'd1 ? {24'd0, duty_q} :
                    bus.address == 2'd2 ? 32'(prescale_q) : {24'd0, blink_half_q};
  end
  // State and configuration registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      enable_q      <= 1'b1;
      blink_en_q    <= 1'b0;
      invert_q      <= 1'b0;
      duty_q        <= 8'hFF;
      prescale_q    <= PRESCALE_W'(PRESCALE_RST);
      blink_half_q  <= 8'(BLINK_RST);
      pre_cnt_q     <= '0;
      pwm_cnt_q     <= 8'd0;
      pattern_q     <= 8'd0;
      blink_cnt_q   <= 8'd0;
      blink_phase_q <= 1'b1;
      led_q         <= 8'd0;
    end else begin
      enable_q      <= enable_d;
      blink_en_q    <= blink_en_d;
      invert_q      <= invert_d;
      duty_q        <= duty_d;
      prescale_q    <= prescale_d;
      blink_half_q  <= blink_half_d;
      pre_cnt_q     <= pre_cnt_d;
      pwm_cnt_q     <= pwm_cnt_d;
      pattern_q     <= pattern_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      led_q         <= led_d;
    end
  end
endmodule

// File: tb/tb_base_hps_led_driver.sv
// tb_base_hps_led_driver: scoreboard bench with a time-based reference model of the LED driver
module tb_base_hps_led_driver;
  localparam int PW = 16;
  localparam int PRE_RST = 49;
  localparam int BLINK_RST = 127;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [7:0] pattern_in = 8'h55;
  logic [7:0] led_out;
  base_hps_led_driver_if bus();
  base_hps_led_driver dut (.clk(clk), .reset_n(reset_n), .pattern_in(pattern_in), .bus(bus.slave), .led_out(led_out));
  always #5 clk = ~clk;
  int passed = 0;
  int total = 0;
  bit m_en, m_ben, m_inv;
  int m_duty, m_pre, m_bhalf, m_since, m_ticks, m_frames;
  logic [7:0] m_pat;
  logic [7:0] exp_q[$];
  logic [31:0] rd_q[$];
  bit t_tick, t_fs, t_on, t_wr, t_clr;
  int t_pwm, t_eff;
  logic [7:0] t_led;
  function automatic int eff(input int d);
`ifdef LED_DRV_GAMMA_EN
    return d == 255 ? 255 : (d * d) >> 8;
`else
    return d;
`endif
  endfunction
  function automatic bit phase();
    return m_ben ? ((m_frames / (m_bhalf + 1)) % 2) == 0 : 1'b1;
  endfunction
  function automatic logic [31:0] exp_read(input logic [1:0] a);
    case (a)
      2'd0: return {23'd0, phase(), 5'd0, m_inv, m_ben, m_en};
      2'd1: return 32'(m_duty);
      2'd2: return 32'(m_pre);
      default: return 32'(m_bhalf);
    endcase
  endfunction
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_en = 1; m_ben = 0; m_inv = 0; m_duty = 255; m_pre = PRE_RST; m_bhalf = BLINK_RST;
      m_since = 0; m_ticks = 0; m_frames = 0; m_pat = 8'h00;
      exp_q.delete();
      exp_q.push_back(8'h00);
    end else begin
      t_pwm  = m_ticks % 256;
      t_tick = (m_since % (m_pre + 1)) == m_pre;
      t_fs   = t_tick && t_pwm == 255;
      t_eff  = eff(m_duty);
      t_on   = t_eff == 255 || t_pwm < t_eff;
      t_led  = m_en ? (m_pat & {8{t_on && phase()}}) : 8'h00;
      exp_q.push_back(t_led ^ {8{m_inv}});
      t_wr   = bus.chipselect && !bus.write_n;
      t_clr  = t_wr && (bus.address == 2'd3 || (bus.address == 2'd0 && bus.writedata[1] != m_ben));
      m_since = (t_wr && bus.address == 2'd2) ? 0 : m_since + 1;
      if (t_tick) m_ticks++;
      if (t_fs) m_pat = pattern_in;
      m_frames = (!m_ben || t_clr) ? 0 : m_frames + int'(t_fs);
      if (t_wr) begin
        case (bus.address)
          2'd0: begin m_en = bus.writedata[0]; m_ben = bus.writedata[1]; m_inv = bus.writedata[2]; end
          2'd1: m_duty = int'(bus.writedata[7:0]);
          2'd2: m_pre = int'(bus.writedata[PW-1:0]);
          default: m_bhalf = int'(bus.writedata[7:0]);
        endcase
      end
    end
  end
  always @(negedge clk) begin
    logic [7:0] e;
    logic [31:0] r;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      total++;
      if (led_out === e) passed++;
      else $display("FAIL led_out t=%0t got %h expected %h", $time, led_out, e);
    end
    if (rd_q.size() != 0) begin
      r = rd_q.pop_front();
      total++;
      if (bus.readdata === r) passed++;
      else $display("FAIL readdata addr=%0d t=%0t got %h expected %h", bus.address, $time, bus.readdata, r);
    end
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s got %h expected %h", name, act, exp);
  endtask
  task automatic wr(input logic [1:0] a, input logic [31:0] d, input bit cs);
    @(posedge clk);
    #2 bus.address = a; bus.writedata = d; bus.chipselect = cs; bus.write_n = 1'b0;
    @(posedge clk);
    #2 bus.chipselect = 1'b0; bus.write_n = 1'b1;
  endtask
  task automatic rd(input logic [1:0] a);
    @(posedge clk);
    #2 bus.address = a; bus.chipselect = 1'b1; bus.write_n = 1'b1;
    rd_q.push_back(exp_read(a));
    @(negedge clk);
    #1 bus.chipselect = 1'b0;
  endtask
  task automatic run(input int n);
    repeat (n) @(posedge clk);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
  initial begin
    bus.address = 2'd0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_led", 32'(led_out), 32'h00);
    #1 chk("reset_ctrl", bus.readdata, 32'h101);
    bus.address = 2'd2;
    #1 chk("reset_prescale", bus.readdata, 32'(PRE_RST));
    @(posedge clk);
    #2 reset_n = 1'b1;
    run(256 * 50);
    @(negedge clk);
    chk("first_frame_before", 32'(led_out), 32'h00);
    @(posedge clk);
    @(negedge clk);
    chk("first_frame_after", 32'(led_out), 32'h55);
    for (int a = 0; a < 4; a++) rd(2'(a));
    run(100);
    pattern_in = 8'hFF;
    wr(2'd2, 32'd0, 1'b1);
    wr(2'd1, 32'd64, 1'b1);
    run(700);
    wr(2'd1, 32'd0, 1'b1);
    run(300);
    wr(2'd1, 32'd255, 1'b1);
    wr(2'd3, 32'd1, 1'b1);
    wr(2'd0, 32'd3, 1'b1);
    for (int i = 0; i < 18; i++) begin
      rd(2'd0);
      run(120);
    end
    wr(2'd0, 32'd1, 1'b1);
    pattern_in = 8'h0F;
    run(400);
    pattern_in = 8'hF0;
    run(400);
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 5))
        0: wr(2'd0, 32'($urandom_range(0, 7)), 1'b1);
        1: wr(2'd1, $urandom(), 1'b1);
        2: wr(2'd2, 32'($urandom_range(0, 3)), 1'b1);
        3: wr(2'd3, 32'($urandom_range(0, 3)), 1'b1);
        4: pattern_in = 8'($urandom());
        default: wr(2'($urandom()), $urandom(), 1'b0);
      endcase
      rd(2'($urandom()));
      run($urandom_range(1, 300));
    end
    wr(2'd1, 32'd64, 1'b1);
    wr(2'd0, 32'd4, 1'b1);
    @(posedge clk);
    @(negedge clk);
    chk("invert_disabled", 32'(led_out), 32'hFF);
    run(37);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1 chk("async_reset_led", 32'(led_out), 32'h00);
    bus.address = 2'd1;
    #1 chk("reset_duty", bus.readdata, 32'd255);
    bus.address = 2'd3;
    #1 chk("reset_blink", bus.readdata, 32'(BLINK_RST));
    run(3);
    #2 reset_n = 1'b1;
    for (int a = 0; a < 4; a++) rd(2'(a));
    run(200);
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
